// File: rtl/mmc_game_master_if.sv
// Host-side channels of the game master: a command channel that starts a
// game and a result channel that returns one record per finished game.
interface mmc_game_master_if #(
   parameter int COUNT_WIDTH = 4,
   parameter int CYC_WIDTH   = 16
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [1:0]             cmd_mode;
   logic [COUNT_WIDTH-1:0] cmd_init_value;

   logic                   res_valid;
   logic                   res_ready;
   logic [1:0]             res_who;
   logic [CYC_WIDTH-1:0]   res_cycles;
   logic                   res_timeout;

   // The host sequencer issues commands and consumes results.
   modport master (
      output cmd_valid, cmd_mode, cmd_init_value, res_ready,
      input  cmd_ready, res_valid, res_who, res_cycles, res_timeout
   );

   // The game master accepts commands and produces results.
   modport slave (
      input  cmd_valid, cmd_mode, cmd_init_value, res_ready,
      output cmd_ready, res_valid, res_who, res_cycles, res_timeout
   );
endinterface

// File: rtl/mmc_game_master.sv
// Command-side driver for the multi-mode counter game. Takes one game request
// at a time, pulses the counter's init, watches for gameover or a timeout,
// then presents a result record and keeps saturating win/loss tallies.
module mmc_game_master #(
   parameter int COUNT_WIDTH    = 4,
   parameter int CYC_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int STAT_WIDTH     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   mmc_game_master_if.slave       host,
   output logic [1:0]             ctr_mode,
   output logic                   ctr_init,
   output logic [COUNT_WIDTH-1:0] ctr_initial_value,
   input  logic                   ctr_gameover,
   input  logic [1:0]             ctr_who,
   output logic [STAT_WIDTH-1:0]  win_total,
   output logic [STAT_WIDTH-1:0]  loss_total
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam logic [CYC_WIDTH:0]     TIMEOUT_CMP = (CYC_WIDTH+1)'(TIMEOUT_CYCLES);
   localparam logic [CYC_WIDTH-1:0]   TIMEOUT_LEN = CYC_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [STAT_WIDTH-1:0]  STAT_MAX    = '1;

   state_t                 state;
   state_t                 state_next;

   logic [CYC_WIDTH-1:0]   cyc;
   logic [CYC_WIDTH:0]     cyc_plus1;
   logic [CYC_WIDTH-1:0]   cyc_plus1_sat;
   logic                   run_timeout;
   logic                   game_end;

   logic                   cmd_ready_c;
   logic                   ctr_init_c;
   logic                   res_valid_c;

   logic [1:0]             res_who_q;
   logic [CYC_WIDTH-1:0]   res_cycles_q;
   logic                   res_timeout_q;

   // The extra top bit lets the timeout compare see cyc+1 without wrapping;
   // the saturated copy is what the counter and the record actually hold.
   assign cyc_plus1     = {1'b0, cyc} + (CYC_WIDTH+1)'(1);
   assign cyc_plus1_sat = (&cyc) ? cyc : cyc_plus1[CYC_WIDTH-1:0];
   assign run_timeout   = (cyc_plus1 == TIMEOUT_CMP);
   assign game_end      = (state == RUN) && (ctr_gameover || run_timeout);

   assign host.cmd_ready   = cmd_ready_c;
   assign host.res_valid   = res_valid_c;
   assign host.res_who     = res_who_q;
   assign host.res_cycles  = res_cycles_q;
   assign host.res_timeout = res_timeout_q;
   assign ctr_init         = ctr_init_c;

   // State register; reset drops any game in progress back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Sequencing and handshake outputs, all decoded from the current state.
   always_comb begin
      state_next  = state;
      cmd_ready_c = 1'b0;
      ctr_init_c  = 1'b0;
      res_valid_c = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready_c = 1'b1;
            if (host.cmd_valid) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            ctr_init_c = 1'b1;
            state_next = RUN;
         end
         RUN: begin
            if (ctr_gameover || run_timeout) begin
               state_next = REPORT;
            end
         end
         REPORT: begin
            res_valid_c = 1'b1;
            if (host.res_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Latch the command for the counter, count RUN cycles and capture the
   // result record; a gameover takes priority over a same-cycle timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_mode          <= 2'b00;
         ctr_initial_value <= '0;
         cyc               <= '0;
         res_who_q         <= 2'b00;
         res_cycles_q      <= '0;
         res_timeout_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (host.cmd_valid) begin
                  ctr_mode          <= host.cmd_mode;
                  ctr_initial_value <= host.cmd_init_value;
                  cyc               <= '0;
               end
            end
            RUN: begin
               cyc <= cyc_plus1_sat;
               if (ctr_gameover) begin
                  res_who_q     <= ctr_who;
                  res_cycles_q  <= cyc_plus1_sat;
                  res_timeout_q <= 1'b0;
               end else if (run_timeout) begin
                  res_who_q     <= 2'b00;
                  res_cycles_q  <= TIMEOUT_LEN;
                  res_timeout_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Tallies step on the way into REPORT so they already include the record
   // being presented; only a real gameover with 10 or 01 counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_total  <= '0;
         loss_total <= '0;
      end else if (game_end && ctr_gameover) begin
         if (ctr_who == 2'b10 && win_total != STAT_MAX) begin
            win_total <= win_total + STAT_WIDTH'(1);
         end
         if (ctr_who == 2'b01 && loss_total != STAT_MAX) begin
            loss_total <= loss_total + STAT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_mmc_game_master.sv
// Bench for mmc_game_master: games described as timelines (gameover position,
// ready delay, reset point) predict every output cycle by cycle, and a
// single compare process checks the DUT against that prediction.
module tb_mmc_game_master;

   localparam int COUNT_WIDTH    = 4;
   localparam int CYC_WIDTH      = 16;
   localparam int TIMEOUT_CYCLES = 20;
   localparam int STAT_WIDTH     = 2;
   localparam int STAT_MAX       = (1 << STAT_WIDTH) - 1;

   typedef struct {
      logic [1:0] mode;
      logic [3:0] val;
      int         gpos;
      logic [1:0] who;
      bit         glitch;
      int         ready_wait;
      bit         early;
      int         idle_wait;
      int         rst_run;
   } game_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             ctr_mode;
   logic                   ctr_init;
   logic [COUNT_WIDTH-1:0] ctr_initial_value;
   logic                   ctr_gameover;
   logic [1:0]             ctr_who;
   logic [STAT_WIDTH-1:0]  win_total;
   logic [STAT_WIDTH-1:0]  loss_total;

   mmc_game_master_if #(.COUNT_WIDTH(COUNT_WIDTH), .CYC_WIDTH(CYC_WIDTH)) host ();

   mmc_game_master #(
      .COUNT_WIDTH(COUNT_WIDTH),
      .CYC_WIDTH(CYC_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .STAT_WIDTH(STAT_WIDTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .host(host),
      .ctr_mode(ctr_mode),
      .ctr_init(ctr_init),
      .ctr_initial_value(ctr_initial_value),
      .ctr_gameover(ctr_gameover),
      .ctr_who(ctr_who),
      .win_total(win_total),
      .loss_total(loss_total)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [1:0] m_mode;
   logic [3:0] m_val;
   int         m_win;
   int         m_loss;

   logic       exp_cmd_ready;
   logic       exp_ctr_init;
   logic       exp_res_valid;
   logic [1:0] exp_ctr_mode;
   logic [3:0] exp_ctr_val;
   int         exp_win;
   int         exp_loss;
   logic [1:0] exp_res_who;
   int         exp_res_cycles;
   logic       exp_res_timeout;

   logic [31:0] obs_load_mode, obs_load_val, obs_who, obs_cycles, obs_to, obs_win, obs_loss;

   game_t games[$];

   task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   task automatic checkOutput();
      checkOne("cmd_ready", 32'(host.cmd_ready), 32'(exp_cmd_ready));
      checkOne("ctr_init", 32'(ctr_init), 32'(exp_ctr_init));
      checkOne("ctr_mode", 32'(ctr_mode), 32'(exp_ctr_mode));
      checkOne("ctr_initial_value", 32'(ctr_initial_value), 32'(exp_ctr_val));
      checkOne("res_valid", 32'(host.res_valid), 32'(exp_res_valid));
      checkOne("win_total", 32'(win_total), 32'(exp_win));
      checkOne("loss_total", 32'(loss_total), 32'(exp_loss));
      if (exp_res_valid) begin
         checkOne("res_who", 32'(host.res_who), 32'(exp_res_who));
         checkOne("res_cycles", 32'(host.res_cycles), 32'(exp_res_cycles));
         checkOne("res_timeout", 32'(host.res_timeout), 32'(exp_res_timeout));
      end
   endtask

   // Compare DUT outputs with the predicted values mid-cycle.
   always @(negedge clk) begin
      if (chk_en) checkOutput();
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic setExp(input logic rdy, input logic init, input logic rv);
      exp_cmd_ready = rdy;
      exp_ctr_init  = init;
      exp_res_valid = rv;
      exp_ctr_mode  = m_mode;
      exp_ctr_val   = m_val;
      exp_win       = m_win;
      exp_loss      = m_loss;
   endtask

   function automatic game_t mkGame(input logic [1:0] mode, input logic [3:0] val, input int gpos,
                                    input logic [1:0] who, input bit glitch, input int ready_wait,
                                    input bit early, input int idle_wait, input int rst_run);
      game_t g;
      g.mode = mode; g.val = val; g.gpos = gpos; g.who = who; g.glitch = glitch;
      g.ready_wait = ready_wait; g.early = early; g.idle_wait = idle_wait; g.rst_run = rst_run;
      return g;
   endfunction

   // Drive one game from its command to the result handshake, predicting
   // each cycle from the game's timeline.
   task automatic applyStimulus(input game_t g, input bit preloaded, input bit present_next,
                                input logic [1:0] nxt_mode, input logic [3:0] nxt_val);
      bit gover;
      int len;
      gover = (g.gpos >= 1 && g.gpos <= TIMEOUT_CYCLES);
      len   = gover ? g.gpos : TIMEOUT_CYCLES;

      if (!preloaded) begin
         for (int i = 0; i < g.idle_wait; i++) begin
            host.cmd_valid = 1'b0;
            host.cmd_mode = 2'($urandom);
            host.cmd_init_value = 4'($urandom);
            ctr_gameover = 1'b0;
            setExp(1'b1, 1'b0, 1'b0);
            step();
         end
      end

      host.cmd_valid = 1'b1;
      host.cmd_mode = g.mode;
      host.cmd_init_value = g.val;
      ctr_gameover = 1'b0;
      setExp(1'b1, 1'b0, 1'b0);
      step();

      m_mode = g.mode;
      m_val  = g.val;
      host.cmd_valid = 1'b0;
      ctr_gameover = g.glitch;
      ctr_who = 2'b10;
      obs_load_mode = 32'(ctr_mode);
      obs_load_val  = 32'(ctr_initial_value);
      setExp(1'b0, 1'b1, 1'b0);
      step();

      for (int r = 1; r <= len; r++) begin
         ctr_gameover = (gover && r == g.gpos);
         ctr_who = (gover && r == g.gpos) ? g.who : 2'($urandom);
         host.res_ready = 1'($urandom);
         if (g.rst_run == r) rst = 1'b1;
         setExp(1'b0, 1'b0, 1'b0);
         step();
         if (g.rst_run == r) begin
            rst = 1'b0;
            ctr_gameover = 1'b0;
            host.res_ready = 1'b0;
            m_mode = 2'b00; m_val = 4'h0; m_win = 0; m_loss = 0;
            obs_win  = 32'(win_total);
            obs_loss = 32'(loss_total);
            for (int i = 0; i < 4; i++) begin
               host.cmd_valid = 1'b0;
               setExp(1'b1, 1'b0, 1'b0);
               step();
            end
            return;
         end
      end

      ctr_gameover = 1'b0;
      exp_res_who     = gover ? g.who : 2'b00;
      exp_res_cycles  = len;
      exp_res_timeout = !gover;
      if (gover && g.who == 2'b10 && m_win < STAT_MAX) m_win++;
      if (gover && g.who == 2'b01 && m_loss < STAT_MAX) m_loss++;
      obs_who    = 32'(host.res_who);
      obs_cycles = 32'(host.res_cycles);
      obs_to     = 32'(host.res_timeout);
      obs_win    = 32'(win_total);
      obs_loss   = 32'(loss_total);
      for (int k = 0; k <= g.ready_wait; k++) begin
         host.res_ready = (k == g.ready_wait);
         if (present_next) begin
            host.cmd_valid = 1'b1;
            host.cmd_mode = nxt_mode;
            host.cmd_init_value = nxt_val;
         end else begin
            host.cmd_valid = 1'b0;
         end
         setExp(1'b0, 1'b0, 1'b1);
         step();
      end
      host.res_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      host.cmd_valid = 1'b0;
      host.cmd_mode = 2'b00;
      host.cmd_init_value = 4'h0;
      host.res_ready = 1'b0;
      ctr_gameover = 1'b0;
      ctr_who = 2'b00;
      m_mode = 2'b00; m_val = 4'h0; m_win = 0; m_loss = 0;
      exp_res_who = 2'b00; exp_res_cycles = 0; exp_res_timeout = 1'b0;
      setExp(1'b1, 1'b0, 1'b0);
      step();
      chk_en = 1'b1;
      step();
      step();
      checkOne("reset_res_who", 32'(host.res_who), 32'd0);
      checkOne("reset_res_cycles", 32'(host.res_cycles), 32'd0);
      checkOne("reset_res_timeout", 32'(host.res_timeout), 32'd0);
      rst = 1'b0;

      games.push_back(mkGame(2'b00, 4'd5, 12, 2'b10, 1'b0, 0, 1'b0, 0, 0));
      games.push_back(mkGame(2'b11, 4'd9, 0, 2'b10, 1'b0, 5, 1'b1, 1, 0));
      games.push_back(mkGame(2'b10, 4'd3, TIMEOUT_CYCLES, 2'b01, 1'b1, 0, 1'b0, 0, 0));
      games.push_back(mkGame(2'b01, 4'd15, 1, 2'b11, 1'b0, 1, 1'b0, 2, 0));
      games.push_back(mkGame(2'b01, 4'd7, 10, 2'b10, 1'b1, 0, 1'b0, 1, 5));
      for (int i = 0; i < 5; i++)
         games.push_back(mkGame(2'($urandom), 4'($urandom), $urandom_range(1, TIMEOUT_CYCLES), 2'b01,
                                1'b0, $urandom_range(0, 2), 1'b0, $urandom_range(0, 1), 0));
      for (int i = 0; i < 25; i++)
         games.push_back(mkGame(2'($urandom), 4'($urandom), $urandom_range(0, TIMEOUT_CYCLES + 5),
                                2'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                                $urandom_range(0, 2),
                                ($urandom_range(0, 9) == 0) ? $urandom_range(1, TIMEOUT_CYCLES) : 0));

      for (int i = 0; i < games.size(); i++) begin
         bit pre, nxt;
         pre = (i > 0) && games[i-1].early;
         nxt = games[i].early && (i + 1 < games.size());
         applyStimulus(games[i], pre, nxt,
                       nxt ? games[i+1].mode : 2'b00, nxt ? games[i+1].val : 4'h0);
         case (i)
            0: begin
               checkOne("lit_load_mode", obs_load_mode, 32'd0);
               checkOne("lit_load_val", obs_load_val, 32'd5);
               checkOne("lit_win_who", obs_who, 32'd2);
               checkOne("lit_win_cycles", obs_cycles, 32'd12);
               checkOne("lit_win_timeout", obs_to, 32'd0);
               checkOne("lit_win_total", obs_win, 32'd1);
            end
            1: begin
               checkOne("lit_to_who", obs_who, 32'd0);
               checkOne("lit_to_cycles", obs_cycles, 32'd20);
               checkOne("lit_to_timeout", obs_to, 32'd1);
               checkOne("lit_to_win", obs_win, 32'd1);
               checkOne("lit_to_loss", obs_loss, 32'd0);
            end
            2: begin
               checkOne("lit_edge_cycles", obs_cycles, 32'd20);
               checkOne("lit_edge_timeout", obs_to, 32'd0);
               checkOne("lit_edge_loss", obs_loss, 32'd1);
            end
            4: begin
               checkOne("lit_rst_win", obs_win, 32'd0);
               checkOne("lit_rst_loss", obs_loss, 32'd0);
            end
            9: checkOne("lit_loss_sat", obs_loss, 32'd3);
            default: begin
            end
         endcase
      end

      host.cmd_valid = 1'b0;
      setExp(1'b1, 1'b0, 1'b0);
      step();
      step();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
